regfile_wb_buffer: RTL and testbench

- Write-back buffer on the writer side of the register file write port.
- Accepts register write requests from the EX/MEM/multi-cycle units through a valid/ready handshake.
- Queues the requests in order and drives the regfile's single we/waddr/wdata port, at most one write per cycle.
- Provides two forwarding lookups so decode can see writes that are queued but not yet retired.

---
 rtl/regfile_wb_buffer_if.sv | 14 +
 rtl/regfile_wb_buffer.sv | 126 ++++++++++++
 tb/tb_regfile_wb_buffer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_buffer_if.sv
// Write-request channel into the register-file write-back buffer.
// The master is the producing execution unit; the slave is the buffer.
interface regfile_wb_buffer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_waddr;
  logic [DATA_W-1:0] in_wdata;

  modport master (output in_valid, in_waddr, in_wdata, input in_ready);
  modport slave  (input in_valid, in_waddr, in_wdata, output in_ready);
endinterface

// File: rtl/regfile_wb_buffer.sv
// In-order write-back buffer driving the single regfile write port, with two
// youngest-first forwarding lookups. Optional WB_COALESCE_EN merges same-register writes.
module regfile_wb_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_buffer_if.slave wr,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] q1_addr,
  output logic              q1_hit,
  output logic [DATA_W-1:0] q1_data,
  input  logic [ADDR_W-1:0] q2_addr,
  output logic              q2_hit,
  output logic [DATA_W-1:0] q2_data,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t PTR_ONE = ptr_t'(1);
  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  ptr_t head, tail, youngest;
  cnt_t count;
  logic push, pop, coalesce, nonzero;

  assign youngest = tail - PTR_ONE;
  assign nonzero  = wr.in_waddr != '0;
  assign pop      = count != '0;

`ifdef WB_COALESCE_EN
  localparam cnt_t CNT_TWO = cnt_t'(2);
  // With count >= 2 the youngest entry is not the one retiring this edge.
  assign coalesce    = (count >= CNT_TWO) && (wr.in_waddr == mem_addr[youngest]);
  assign wr.in_ready = (count < DEPTH_C) || coalesce;
`else
  assign coalesce    = 1'b0;
  assign wr.in_ready = count < DEPTH_C;
`endif

  // Writes to r0 complete the handshake but never occupy an entry.
  assign push = wr.in_valid && wr.in_ready && nonzero && !coalesce;
  assign busy = pop || we;

  // NOTE: entry storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail] <= wr.in_waddr;
      mem_data[tail] <= wr.in_wdata;
    end else if (wr.in_valid && coalesce) begin
      mem_data[youngest] <= wr.in_wdata;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every update
  // in this block sees the pre-edge values of count, head and tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= pop;
      if (push) tail <= tail + PTR_ONE;
      if (pop) begin
        head  <= head + PTR_ONE;
        waddr <= mem_addr[head];
        wdata <= mem_data[head];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  logic [1:0][ADDR_W-1:0] q_addr;
  assign q_addr = {q2_addr, q1_addr};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    logic              hit;
    logic [DATA_W-1:0] data;

    // NOTE: outputs get defaults first so no path leaves them unassigned.
    always_comb begin
      hit  = 1'b0;
      data = '0;
      if (q_addr[g] != '0) begin
        if (we && waddr == q_addr[g]) begin
          hit  = 1'b1;
          data = wdata;
        end
        // Scan oldest to youngest so the last match, the youngest, wins.
        for (int i = 0; i < DEPTH; i++) begin
          if (cnt_t'(i) < count && mem_addr[head + ptr_t'(i)] == q_addr[g]) begin
            hit  = 1'b1;
            data = mem_data[head + ptr_t'(i)];
          end
        end
      end
    end
  end

  assign q1_hit  = g_fwd[0].hit;
  assign q1_data = g_fwd[0].data;
  assign q2_hit  = g_fwd[1].hit;
  assign q2_data = g_fwd[1].data;

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Self-checking bench for regfile_wb_buffer: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_regfile_wb_buffer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr ();

  logic              we, q1_hit, q2_hit, busy;
  logic [ADDR_W-1:0] waddr, q1_addr, q2_addr;
  logic [DATA_W-1:0] wdata, q1_data, q2_data;

  regfile_wb_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .wr     (wr),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .q1_addr(q1_addr),
    .q1_hit (q1_hit),
    .q1_data(q1_data),
    .q2_addr(q2_addr),
    .q2_hit (q2_hit),
    .q2_data(q2_data),
    .busy   (busy)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  // Reference model: pending writes in arrival order plus the regfile port.
  wr_t               mq[$];
  logic              m_we;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  function automatic logic model_coalesce(input logic [ADDR_W-1:0] a);
`ifdef WB_COALESCE_EN
    return a != '0 && mq.size() >= 2 && mq[mq.size()-1].a == a;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic model_ready(input logic [ADDR_W-1:0] a);
    return mq.size() < DEPTH || model_coalesce(a);
  endfunction

  function automatic void model_lookup(input logic [ADDR_W-1:0] qa,
                                       output logic hit, output logic [DATA_W-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (qa == '0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == qa) begin
        hit  = 1'b1;
        data = mq[i].d;
        return;
      end
    end
    if (m_we && m_waddr == qa) begin
      hit  = 1'b1;
      data = m_wdata;
    end
  endfunction

  task automatic compare_all();
    logic              eh;
    logic [DATA_W-1:0] ed;
    check("in_ready", wr.in_ready, model_ready(wr.in_waddr));
    check("we", we, m_we);
    check("waddr", waddr, m_waddr);
    check("wdata", wdata, m_wdata);
    check("busy", busy, mq.size() != 0 || m_we);
    model_lookup(q1_addr, eh, ed);
    check("q1_hit", q1_hit, eh);
    check("q1_data", q1_data, ed);
    model_lookup(q2_addr, eh, ed);
    check("q2_hit", q2_hit, eh);
    check("q2_data", q2_data, ed);
  endtask

  // Advance one clock: the model pops from pre-edge state, then accepts.
  task automatic tick();
    logic              acc, coal, do_pop;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    wr_t               e;
    a      = wr.in_waddr;
    d      = wr.in_wdata;
    acc    = wr.in_valid && model_ready(a);
    coal   = acc && model_coalesce(a);
    do_pop = mq.size() != 0;
    @(posedge clk);
    if (do_pop) begin
      e       = mq.pop_front();
      m_we    = 1'b1;
      m_waddr = e.a;
      m_wdata = e.d;
    end else begin
      m_we = 1'b0;
    end
    if (acc && a != '0) begin
      if (coal) mq[mq.size()-1].d = d;
      else      mq.push_back('{a: a, d: d});
    end
    @(negedge clk);
  endtask

  task automatic cycle(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [ADDR_W-1:0] qa1, input logic [ADDR_W-1:0] qa2);
    wr.in_valid = v;
    wr.in_waddr = a;
    wr.in_wdata = d;
    q1_addr     = qa1;
    q2_addr     = qa2;
    #1;
    compare_all();
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    wr.in_valid = 1'b0;
    wr.in_waddr = '0;
    wr.in_wdata = '0;
    q1_addr     = '0;
    q2_addr     = '0;
    model_reset();

    #1;
    check("rst_we", we, 1'b0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Single write: visible on the port after the second edge, gone after the third.
    cycle(1'b1, 5'd3, 32'h1234_5678, '0, '0);
    cycle(1'b0, '0, '0, '0, '0);
    check("lat_we", we, 1'b1);
    check("lat_waddr", waddr, 3);
    check("lat_wdata", wdata, 32'h1234_5678);
    cycle(1'b0, '0, '0, '0, '0);
    check("lat_we_off", we, 1'b0);
    check("lat_busy_off", busy, 1'b0);

    // r0 is accepted but dropped.
    wr.in_valid = 1'b1;
    wr.in_waddr = '0;
    wr.in_wdata = 32'hDEAD_BEEF;
    #1;
    check("r0_ready", wr.in_ready, 1'b1);
    tick();
    cycle(1'b0, '0, '0, '0, '0);
    check("r0_we", we, 1'b0);
    check("r0_busy", busy, 1'b0);
    check("r0_q1_hit", q1_hit, 1'b0);

    // r5, r6, r5 back to back; forward from queue and from the output register.
    cycle(1'b1, 5'd5, 32'd1, 5'd5, 5'd6);
    cycle(1'b1, 5'd6, 32'd2, 5'd5, 5'd6);
    cycle(1'b1, 5'd5, 32'd3, 5'd5, 5'd6);
    wr.in_valid = 1'b0;
    q1_addr     = 5'd5;
    q2_addr     = 5'd6;
    #1;
    check("fwd_q1_hit", q1_hit, 1'b1);
    check("fwd_q1_data", q1_data, 3);
    check("fwd_q2_hit", q2_hit, 1'b1);
    check("fwd_q2_data", q2_data, 2);
    tick();
    idle(2);

    // Same register in output register and queue: the queued, younger value wins.
    cycle(1'b1, 5'd8, 32'h11, 5'd8, '0);
    cycle(1'b1, 5'd8, 32'h22, 5'd8, '0);
    wr.in_valid = 1'b0;
    q1_addr     = 5'd8;
    #1;
    check("young_q1_data", q1_data, 32'h22);
    tick();
    idle(2);

    // Continuous valid for six cycles with distinct targets.
    for (int i = 1; i <= 6; i++)
      cycle(1'b1, ADDR_W'(i), DATA_W'(32'h100 + i), ADDR_W'(i), ADDR_W'(i - 1));
    idle(3);

    // Asynchronous reset in the middle of a stream.
    cycle(1'b1, 5'd9, 32'h99, '0, '0);
    cycle(1'b1, 5'd10, 32'hAA, 5'd10, '0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_we", we, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_q1_hit", q1_hit, 1'b0);
    model_reset();
    wr.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(3);

    // Two writes to r7; under steady retirement both reach the port in order.
    cycle(1'b1, 5'd7, 32'hA, 5'd7, '0);
    cycle(1'b1, 5'd7, 32'hB, 5'd7, '0);
    idle(3);

    // Random traffic over a small address set to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 7)), $urandom,
            ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
    end
    idle(4);
    check("drain_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
